// File: rtl/ccff_stream_loader.sv
// Serialises valid/ready config words MSB-first onto ccff_head, one bit per prog_clk; first bit one cycle after transfer.
// Backpressure: cfg_ready only in LOAD or at a word boundary with chain bits remaining; underrun holds the chain.
module ccff_stream_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 64,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] cfg_word,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  ccff_head,
  output logic                  chain_shift_en,
  input  logic                  ccff_tail,
  output logic                  cfg_done,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  bit_count
);

  localparam int IDX_W = $clog2(WORD_WIDTH);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(WORD_WIDTH - 1);
  localparam logic [CNT_WIDTH:0] CHAIN_LEN = (CNT_WIDTH + 1)'(CHAIN_LENGTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_dec;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH:0]    cnt_inc;
  logic                  head_q, head_d;
  logic                  shift_q, shift_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  last_bit, word_end, xfer;

  // The tail echo is not used by this loader's control path.
  logic unused_tail;
  assign unused_tail = ccff_tail;

  assign cnt_inc  = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(1);
  assign idx_dec  = idx_q - IDX_W'(1);
  assign last_bit = (state_q == SHIFT) && (cnt_inc == CHAIN_LEN);
  assign word_end = (state_q == SHIFT) && (idx_q == '0) && !last_bit;

  assign cfg_ready = (state_q == LOAD) || word_end;
  assign xfer      = cfg_valid && cfg_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    head_d  = 1'b0;
    shift_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (xfer) begin
          state_d = SHIFT;
          shreg_d = cfg_word;
          idx_d   = LAST_IDX;
          head_d  = cfg_word[WORD_WIDTH-1];
          shift_d = 1'b1;
        end
      end
      SHIFT: begin
        cnt_d = cnt_inc[CNT_WIDTH-1:0];
        // The chain-length limit wins over the word boundary: leftover bits are dropped.
        if (last_bit) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (idx_q == '0) begin
          if (xfer) begin
            shreg_d = cfg_word;
            idx_d   = LAST_IDX;
            head_d  = cfg_word[WORD_WIDTH-1];
            shift_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else begin
          idx_d   = idx_dec;
          head_d  = shreg_q[idx_dec];
          shift_d = 1'b1;
        end
      end
      DONE: begin
        done_d = 1'b1;
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == SHIFT);
  end

  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      head_q  <= 1'b0;
      shift_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign ccff_head      = head_q;
  assign chain_shift_en = shift_q;
  assign cfg_done       = done_q;
  assign busy           = busy_q;
  assign bit_count      = cnt_q;

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Bench for ccff_stream_loader: u0 drives a 16-flop chain, u1 a 12-flop chain (partial last word).
// Expected stream is the concatenation of presented words, MSB first, cut at the chain length.
module tb_ccff_stream_loader;

  localparam int WW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_s[2];
  logic [7:0]  word_s[2];
  logic        valid_s[2];
  logic        ready_s[2];
  logic        head_s[2];
  logic        shen_s[2];
  logic        tail_s[2];
  logic        done_s[2];
  logic        busy_s[2];
  logic [15:0] cnt_s[2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] wq[8];
  int         gq[8];

  always #5 clk = ~clk;

  ccff_stream_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(16), .CNT_WIDTH(16)) u0 (
    .prog_clk(clk), .prog_reset(rst_n), .start(start_s[0]), .cfg_word(word_s[0]),
    .cfg_valid(valid_s[0]), .cfg_ready(ready_s[0]), .ccff_head(head_s[0]),
    .chain_shift_en(shen_s[0]), .ccff_tail(tail_s[0]), .cfg_done(done_s[0]),
    .busy(busy_s[0]), .bit_count(cnt_s[0])
  );

  ccff_stream_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(12), .CNT_WIDTH(16)) u1 (
    .prog_clk(clk), .prog_reset(rst_n), .start(start_s[1]), .cfg_word(word_s[1]),
    .cfg_valid(valid_s[1]), .cfg_ready(ready_s[1]), .ccff_head(head_s[1]),
    .chain_shift_en(shen_s[1]), .ccff_tail(tail_s[1]), .cfg_done(done_s[1]),
    .busy(busy_s[1]), .bit_count(cnt_s[1])
  );

  function automatic int cl_of(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s[u%0d]: observed %0h, expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic check_idle(input int d);
    chk("idle_ready", d, 32'(ready_s[d]), 32'd0);
    chk("idle_head",  d, 32'(head_s[d]),  32'd0);
    chk("idle_shen",  d, 32'(shen_s[d]),  32'd0);
    chk("idle_done",  d, 32'(done_s[d]),  32'd0);
    chk("idle_busy",  d, 32'(busy_s[d]),  32'd0);
    chk("idle_cnt",   d, 32'(cnt_s[d]),   32'd0);
  endtask

  task automatic check_done(input int d);
    chk("done_flag",  d, 32'(done_s[d]),  32'd1);
    chk("done_busy",  d, 32'(busy_s[d]),  32'd0);
    chk("done_shen",  d, 32'(shen_s[d]),  32'd0);
    chk("done_head",  d, 32'(head_s[d]),  32'd0);
    chk("done_ready", d, 32'(ready_s[d]), 32'd0);
    chk("done_cnt",   d, 32'(cnt_s[d]),   32'(cl_of(d)));
  endtask

  // One load of wq[0..nw-1]; word i is offered gq[i] cycles after the previous transfer.
  // mid_start pulses start while shifting bit 3; abort_at >= 0 resets while shifting that bit.
  task automatic run_load(input int d, input int nw, input bit mid_start, input int abort_at);
    int nbits, xf, wi, since, cyc, avail, cl;
    bit exp_sh, exp_rdy, present;
    logic [7:0] w;
    cl = cl_of(d);
    nbits = 0; xf = 0; wi = 0; since = 0; cyc = 0;
    @(negedge clk);
    start_s[d] = 1'b1;
    @(negedge clk);
    while (cyc < 200 && nbits < cl) begin
      avail   = xf * WW - nbits;
      exp_sh  = (avail > 0);
      exp_rdy = (avail == 0) || (avail == 1 && nbits + 1 < cl);
      present = (wi < nw) && (since >= gq[wi]);
      start_s[d] = mid_start && exp_sh && (nbits == 3);
      valid_s[d] = present;
      word_s[d]  = present ? wq[wi] : 8'($urandom);
      tail_s[d]  = 1'($urandom);
      chk("shift_en", d, 32'(shen_s[d]),  32'(exp_sh));
      chk("ready",    d, 32'(ready_s[d]), 32'(exp_rdy));
      chk("busy",     d, 32'(busy_s[d]),  32'd1);
      chk("done_lo",  d, 32'(done_s[d]),  32'd0);
      chk("bit_count", d, 32'(cnt_s[d]),  32'(nbits));
      if (exp_sh) begin
        w = wq[nbits / WW];
        chk("head", d, 32'(head_s[d]), 32'(w[WW - 1 - (nbits % WW)]));
      end
      if (abort_at >= 0 && exp_sh && nbits == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_idle(d);
        valid_s[d] = 1'b0;
        start_s[d] = 1'b0;
        repeat (2) @(negedge clk);
        check_idle(d);
        rst_n = 1'b1;
        return;
      end
      if (present && exp_rdy) begin
        xf++; wi++; since = 0;
      end else begin
        since++;
      end
      if (exp_sh) nbits++;
      cyc++;
      @(negedge clk);
    end
    valid_s[d] = 1'b0;
    start_s[d] = 1'b0;
    chk("load_within_budget", d, 32'(nbits), 32'(cl));
    check_done(d);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; word_s[i] = '0; valid_s[i] = 1'b0; tail_s[i] = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      wq[i] = '0; gq[i] = 0;
    end

    // Reset held three cycles, then idle with no start.
    repeat (3) @(negedge clk);
    check_idle(0);
    check_idle(1);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_idle(0);
      check_idle(1);
    end

    // Back-to-back streaming of A5, 3C.
    wq[0] = 8'hA5; wq[1] = 8'h3C; gq[0] = 0; gq[1] = 0;
    run_load(0, 2, 1'b0, -1);

    // Second word withheld: offered five cycles after the boundary.
    gq[1] = WW + 5;
    run_load(0, 2, 1'b0, -1);

    // Partial final word on the 12-flop chain.
    wq[0] = 8'hFF; wq[1] = 8'h90; gq[0] = 0; gq[1] = 0;
    run_load(1, 2, 1'b0, -1);

    // Reset in the middle of shifting bit 5, then a clean reload.
    wq[0] = 8'hA5; wq[1] = 8'h3C;
    run_load(0, 2, 1'b0, 5);
    check_idle(1);
    run_load(0, 2, 1'b0, -1);

    // Start during SHIFT is ignored; start from DONE restarts identically.
    run_load(0, 2, 1'b1, -1);
    run_load(0, 2, 1'b0, -1);

    // Random words and random presentation gaps on both chains.
    for (int t = 0; t < 8; t++) begin
      int d;
      d = int'($urandom_range(0, 1));
      wq[0] = 8'($urandom); wq[1] = 8'($urandom);
      gq[0] = int'($urandom_range(0, 3));
      gq[1] = int'($urandom_range(0, 12));
      run_load(d, 2, 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
